// File: rtl/pong_pkg.sv
// Shared Pong timing definitions: state encodings, speed field width,
// default speed constants and small helpers used by the speed controller
// and the clock divider instance.
package pong_pkg;

   localparam int HZ_WIDTH = 11;

   localparam int HZ_BASE_DEF     = 60;
   localparam int HZ_STEP_DEF     = 4;
   localparam int HZ_MAX_DEF      = 240;
   localparam int SERVE_TICKS_DEF = 90;
   localparam int POINT_TICKS_DEF = 120;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SERVE = 2'b01,
      ST_PLAY  = 2'b10,
      ST_POINT = 2'b11
   } game_state_e;

   // Larger of two integers, used to size the shared pause counter.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Speed ramp: one extra bit of headroom, then clamp to the ceiling.
   function automatic logic [HZ_WIDTH-1:0] hz_ramp(
      input logic [HZ_WIDTH-1:0] hz,
      input logic [HZ_WIDTH-1:0] step,
      input logic [HZ_WIDTH-1:0] ceil
   );
      logic [HZ_WIDTH:0] sum;
      sum = {1'b0, hz} + {1'b0, step};
      if (sum > {1'b0, ceil}) begin
         return ceil;
      end
      return sum[HZ_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/game_speed_controller_if.sv
// Bundle between the game sequencer and the rest of the Pong top level:
// divider output and game events in, speed / tick / motion gating out.
// The controller side is the slave; the surrounding game logic is master.
// Every signal is a plain level or single-cycle pulse sampled on clock_in;
// there is no valid/ready handshake on this bundle.
interface game_speed_controller_if;
   import pong_pkg::*;

   logic                div_clk;
   logic                start;
   logic                pause;
   logic                paddle_hit;
   logic                point_scored;
   logic [HZ_WIDTH-1:0] hz_out;
   logic                game_tick;
   logic                ball_run;
   game_state_e         state;

   modport master (
      output div_clk, start, pause, paddle_hit, point_scored,
      input  hz_out, game_tick, ball_run, state
   );

   modport slave (
      input  div_clk, start, pause, paddle_hit, point_scored,
      output hz_out, game_tick, ball_run, state
   );

endinterface

// File: rtl/tick_edge_detect.sv
// Turns a square wave already in the clock_in domain into a registered
// one-cycle pulse per rising edge. While en is low, edges are dropped
// (not deferred), because sig_q keeps tracking sig regardless of en.
module tick_edge_detect (
   input  logic clock_in,
   input  logic reset_n,
   input  logic sig,
   input  logic en,
   output logic pulse
);

   logic sig_q;
   logic pulse_q;
   logic raw_tick;

   assign raw_tick = sig & ~sig_q;

   // Delay line for edge detection plus the registered, gated pulse.
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         sig_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sig_q   <= sig;
         pulse_q <= raw_tick & en;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/game_speed_controller.sv
// Pong game sequencer: converts the divider square wave into game ticks,
// steps IDLE -> SERVE -> PLAY -> POINT -> SERVE, gates ball motion and
// ramps the divider speed on every paddle hit.
module game_speed_controller
   import pong_pkg::*;
#(
   parameter int HZ_BASE     = HZ_BASE_DEF,
   parameter int HZ_STEP     = HZ_STEP_DEF,
   parameter int HZ_MAX      = HZ_MAX_DEF,
   parameter int SERVE_TICKS = SERVE_TICKS_DEF,
   parameter int POINT_TICKS = POINT_TICKS_DEF
) (
   input  logic                    clock_in,
   input  logic                    reset_n,
   game_speed_controller_if.slave  gsc
);

   localparam int CNT_W = $clog2(max_int(SERVE_TICKS, POINT_TICKS) + 1);

   localparam logic [HZ_WIDTH-1:0] HZ_BASE_V = HZ_WIDTH'(HZ_BASE);
   localparam logic [HZ_WIDTH-1:0] HZ_STEP_V = HZ_WIDTH'(HZ_STEP);
   localparam logic [HZ_WIDTH-1:0] HZ_MAX_V  = HZ_WIDTH'(HZ_MAX);
   localparam logic [CNT_W-1:0]    SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
   localparam logic [CNT_W-1:0]    POINT_LAST = CNT_W'(POINT_TICKS - 1);

   game_state_e          state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [HZ_WIDTH-1:0]  hz_q;
   logic [HZ_WIDTH-1:0]  hz_inc_d;
   logic                 game_tick;
   logic                 frozen;

   // Ticks are suppressed whenever pause is high, in any state.
   tick_edge_detect u_tick (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .sig      (gsc.div_clk),
      .en       (~gsc.pause),
      .pulse    (game_tick)
   );

   assign hz_inc_d = hz_ramp(hz_q, HZ_STEP_V, HZ_MAX_V);
   assign frozen   = gsc.pause;

   // Sequencer: state, pause counter and speed all live in one register block.
   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hz_q    <= HZ_BASE_V;
      end else begin
         case (state_q)
            ST_IDLE: begin
               hz_q  <= HZ_BASE_V;
               cnt_q <= '0;
               if (gsc.start) begin
                  state_q <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (!frozen && game_tick) begin
                  if (cnt_q == SERVE_LAST) begin
                     state_q <= ST_PLAY;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            ST_PLAY: begin
               // A score outranks a hit arriving in the same cycle.
               if (!frozen) begin
                  if (gsc.point_scored) begin
                     state_q <= ST_POINT;
                     cnt_q   <= '0;
                     hz_q    <= HZ_BASE_V;
                  end else if (gsc.paddle_hit) begin
                     hz_q <= hz_inc_d;
                  end
               end
            end
            ST_POINT: begin
               if (!frozen && game_tick) begin
                  if (cnt_q == POINT_LAST) begin
                     state_q <= ST_SERVE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               hz_q    <= HZ_BASE_V;
            end
         endcase
      end
   end

   // The divider divides by hz_out, so a zero must never leave this block.
   assign gsc.hz_out    = (hz_q == '0) ? HZ_BASE_V : hz_q;
   assign gsc.game_tick = game_tick;
   assign gsc.ball_run  = (state_q == ST_PLAY) & ~gsc.pause;
   assign gsc.state     = state_q;

endmodule

// File: tb/tb_game_speed_controller.sv
// Bench for game_speed_controller: two instances (base 60 and base 230)
// share one stimulus stream; a behavioural model predicts every output on
// every cycle and directed literal checks pin the model at key points.
module tb_game_speed_controller;
   import pong_pkg::*;

   localparam int STEP   = 4;
   localparam int MAXHZ  = 240;
   localparam int SERVE  = 3;
   localparam int POINT  = 4;
   localparam int BASE_A = 60;
   localparam int BASE_B = 230;

   // ---------------- clock / reset ----------------
   logic clock_in = 1'b0;
   logic reset_n  = 1'b0;
   always #5 clock_in = ~clock_in;

   logic start        = 1'b0;
   logic pause        = 1'b0;
   logic paddle_hit   = 1'b0;
   logic point_scored = 1'b0;
   logic div_clk      = 1'b0;

   game_speed_controller_if if_a ();
   game_speed_controller_if if_b ();

   assign if_a.div_clk      = div_clk;
   assign if_a.start        = start;
   assign if_a.pause        = pause;
   assign if_a.paddle_hit   = paddle_hit;
   assign if_a.point_scored = point_scored;
   assign if_b.div_clk      = div_clk;
   assign if_b.start        = start;
   assign if_b.pause        = pause;
   assign if_b.paddle_hit   = paddle_hit;
   assign if_b.point_scored = point_scored;

   game_speed_controller #(
      .HZ_BASE(BASE_A), .HZ_STEP(STEP), .HZ_MAX(MAXHZ),
      .SERVE_TICKS(SERVE), .POINT_TICKS(POINT)
   ) u_dut_a (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .gsc      (if_a.slave)
   );

   game_speed_controller #(
      .HZ_BASE(BASE_B), .HZ_STEP(STEP), .HZ_MAX(MAXHZ),
      .SERVE_TICKS(SERVE), .POINT_TICKS(POINT)
   ) u_dut_b (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .gsc      (if_b.slave)
   );

   // ---------------- bookkeeping ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // ---------------- divider stand-in: period 10 cycles ----------------
   bit div_run  = 1'b0;
   int div_ph   = 9;
   int rise_cyc = 0;
   int rise_n   = 0;

   always @(negedge clock_in) begin
      #1;
      if (div_run) begin
         div_ph = (div_ph + 1) % 10;
         if (div_ph == 0) begin
            rise_cyc = cyc_n;
            rise_n++;
         end
         div_clk = (div_ph < 5);
      end else begin
         div_ph  = 9;
         div_clk = 1'b0;
      end
   end

   // ---------------- behavioural model ----------------
   // m_state: 0 idle, 1 serve, 2 play, 3 point. m_cnt counts ticks seen
   // in the current waiting state; the move happens when it reaches the total.
   int m_state = 0;
   int m_cnt   = 0;
   int m_hz[2] = '{BASE_A, BASE_B};
   bit m_tick  = 1'b0;
   bit m_prev  = 1'b0;
   bit m_tick_in;

   always @(posedge clock_in) begin
      cyc_n++;
      if (!reset_n) begin
         m_state = 0;
         m_cnt   = 0;
         m_hz    = '{BASE_A, BASE_B};
         m_tick  = 1'b0;
         m_prev  = 1'b0;
      end else begin
         m_tick_in = m_tick;
         m_tick    = div_clk && !m_prev && !pause;
         m_prev    = div_clk;
         if (m_state == 0) begin
            m_hz = '{BASE_A, BASE_B};
            if (start) begin
               m_state = 1;
               m_cnt   = 0;
            end
         end else if (!pause) begin
            if (m_state == 2) begin
               if (point_scored) begin
                  m_state = 3;
                  m_cnt   = 0;
                  m_hz    = '{BASE_A, BASE_B};
               end else if (paddle_hit) begin
                  for (int k = 0; k < 2; k++) begin
                     m_hz[k] = (m_hz[k] + STEP > MAXHZ) ? MAXHZ : m_hz[k] + STEP;
                  end
               end
            end else if (m_tick_in) begin
               m_cnt++;
               if (m_state == 1 && m_cnt == SERVE) begin
                  m_state = 2;
                  m_cnt   = 0;
               end else if (m_state == 3 && m_cnt == POINT) begin
                  m_state = 1;
                  m_cnt   = 0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clock_in) begin
      if (cyc_n > 0) begin
         check("state_a", if_a.state, m_state);
         check("state_b", if_b.state, m_state);
         check("hz_a", if_a.hz_out, m_hz[0]);
         check("hz_b", if_b.hz_out, m_hz[1]);
         check("tick_a", if_a.game_tick, m_tick);
         check("tick_b", if_b.game_tick, m_tick);
         check("run_a", if_a.ball_run, (m_state == 2) && !pause);
         check("run_b", if_b.ball_run, (m_state == 2) && !pause);
         check("hz_nonzero", (if_a.hz_out != 0) && (if_b.hz_out != 0), 1);
         if (if_a.game_tick) begin
            check("tick_latency", cyc_n - rise_cyc, 1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(negedge clock_in);
      #1;
   endtask

   task automatic wait_state(input int target, input int budget, output int ticks, output bit ok);
      ticks = 0;
      ok    = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (if_a.game_tick) ticks++;
         if (int'(if_a.state) == target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic hit_pulse();
      paddle_hit = 1'b1;
      cyc();
      paddle_hit = 1'b0;
      cyc();
   endtask

   // ---------------- main sequence ----------------
   int n;
   bit ok;
   int r0;
   int exp_b[4];

   initial begin
      exp_b = '{234, 238, 240, 240};

      // Reset and idle hold
      repeat (3) cyc();
      reset_n = 1'b1;
      n = 0;
      repeat (100) begin
         cyc();
         if (if_a.game_tick) n++;
      end
      check("idle_state", if_a.state, 0);
      check("idle_hz_a", if_a.hz_out, 60);
      check("idle_hz_b", if_b.hz_out, 230);
      check("idle_no_tick", n, 0);
      check("idle_run", if_a.ball_run, 0);

      // Start pulse
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("start_state", if_a.state, 1);

      // Serve delay of three ticks
      div_run = 1'b1;
      wait_state(2, 100, n, ok);
      check("serve_to_play", ok, 1);
      check("serve_ticks", n, 3);
      check("play_run", if_a.ball_run, 1);

      // Ramp and saturation
      for (int i = 0; i < 4; i++) begin
         paddle_hit = 1'b1;
         cyc();
         paddle_hit = 1'b0;
         check("ramp_b", if_b.hz_out, exp_b[i]);
         check("ramp_a", if_a.hz_out, 64 + 4 * i);
         cyc();
      end
      repeat (6) hit_pulse();
      check("hz_a_100", if_a.hz_out, 100);

      // Simultaneous hit and score
      paddle_hit   = 1'b1;
      point_scored = 1'b1;
      cyc();
      paddle_hit   = 1'b0;
      point_scored = 1'b0;
      check("simul_state", if_a.state, 3);
      check("simul_hz_a", if_a.hz_out, 60);
      check("simul_hz_b", if_b.hz_out, 230);
      wait_state(1, 200, n, ok);
      check("point_to_serve", ok, 1);
      check("point_ticks", n, 4);

      // Pause in SERVE after the first tick
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (if_a.game_tick) begin
            ok = 1'b1;
            break;
         end
      end
      check("serve_first_tick", ok, 1);
      cyc();
      pause = 1'b1;
      r0 = rise_n;
      n  = 0;
      for (int i = 0; i < 60 && rise_n < r0 + 3; i++) begin
         paddle_hit   = (i == 2);
         point_scored = (i == 4);
         cyc();
         if (if_a.game_tick) n++;
      end
      paddle_hit   = 1'b0;
      point_scored = 1'b0;
      repeat (2) begin
         cyc();
         if (if_a.game_tick) n++;
      end
      check("pause_edges", rise_n - r0, 3);
      check("pause_no_tick", n, 0);
      check("pause_state", if_a.state, 1);
      check("pause_run", if_a.ball_run, 0);
      pause = 1'b0;
      wait_state(2, 100, n, ok);
      check("resume_to_play", ok, 1);
      check("resume_ticks", n, 2);

      // Pause in PLAY holds speed and ignores events
      pause = 1'b1;
      cyc();
      check("play_pause_run", if_a.ball_run, 0);
      hit_pulse();
      point_scored = 1'b1;
      cyc();
      point_scored = 1'b0;
      cyc();
      check("play_pause_hz", if_a.hz_out, 60);
      check("play_pause_state", if_a.state, 2);
      pause = 1'b0;
      cyc();
      check("play_resume_run", if_a.ball_run, 1);

      // Reset mid-play
      repeat (35) hit_pulse();
      check("hz_a_200", if_a.hz_out, 200);
      check("hz_b_sat", if_b.hz_out, 240);
      reset_n    = 1'b0;
      start      = 1'b1;
      paddle_hit = 1'b1;
      cyc();
      reset_n    = 1'b1;
      start      = 1'b0;
      paddle_hit = 1'b0;
      check("rst_state", if_a.state, 0);
      check("rst_hz_a", if_a.hz_out, 60);
      check("rst_hz_b", if_b.hz_out, 230);
      check("rst_run", if_a.ball_run, 0);
      check("rst_tick", if_a.game_tick, 0);
      repeat (5) cyc();
      div_run = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
